// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the IF/ID and ID/EX pipeline registers of the 5-stage core:
// load-use stalls, branch flushes, multiply occupancy of EX, memory freezes, stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [4:0]        IDEX_RTaddr_i,
    input  logic [4:0]        IFID_RSaddr_i,
    input  logic [4:0]        IFID_RTaddr_i,
    input  logic              ID_UsesRT_i,
    input  logic              ID_Branch_i,
    input  logic              ID_Mul_i,
    input  logic              MemStall_i,
    output logic              PC_write_o,
    output logic              IFID_write_o,
    output logic              IFID_flush_o,
    output logic              IDEX_write_o,
    output logic              IDEX_bubble_o,
    output logic              freeze_o,
    output logic              mul_busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    localparam int unsigned MCNT_W = 3;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [MCNT_W-1:0]   mcnt_q;
    logic [MCNT_W-1:0]   mcnt_d;
    logic                load_use;

    // Load in EX whose destination feeds a source of the instruction in ID ($0 never hazards)
    assign load_use = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                      ((IDEX_RTaddr_i == IFID_RSaddr_i) ||
                       (ID_UsesRT_i && (IDEX_RTaddr_i == IFID_RTaddr_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            mcnt_q      <= '0;
            stall_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            if (!PC_write_o) begin
                stall_cnt_o <= stall_cnt_o + PERF_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mcnt_d        = mcnt_q;
        PC_write_o    = 1'b0;
        IFID_write_o  = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_write_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        mul_busy_o    = 1'b0;

        if (rst_i) begin
            // Drain bubbles into ID/EX and IF/ID while reset is held
            IFID_flush_o  = 1'b1;
            IDEX_write_o  = 1'b1;
            IDEX_bubble_o = 1'b1;
            state_d       = RUN;
            mcnt_d        = '0;
        end else if (MemStall_i) begin
            freeze_o   = 1'b1;
            mul_busy_o = (state_q == MUL_BUSY);
        end else if (state_q == MUL_BUSY) begin
            mul_busy_o = 1'b1;
            mcnt_d     = mcnt_q - MCNT_W'(1);
            if (mcnt_q <= MCNT_W'(1)) begin
                state_d = RUN;
                mcnt_d  = '0;
            end
        end else if (load_use) begin
            IDEX_write_o  = 1'b1;
            IDEX_bubble_o = 1'b1;
        end else begin
            PC_write_o   = 1'b1;
            IFID_write_o = 1'b1;
            IDEX_write_o = 1'b1;
            if (ID_Branch_i) begin
                IFID_flush_o = 1'b1;
            end else if (ID_Mul_i) begin
                state_d = MUL_BUSY;
                mcnt_d  = MCNT_W'(MUL_LAT - 1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned ML = 4;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          IDEX_MemRead_i;
    logic [4:0]    IDEX_RTaddr_i;
    logic [4:0]    IFID_RSaddr_i;
    logic [4:0]    IFID_RTaddr_i;
    logic          ID_UsesRT_i;
    logic          ID_Branch_i;
    logic          ID_Mul_i;
    logic          MemStall_i;
    logic          PC_write_o;
    logic          IFID_write_o;
    logic          IFID_flush_o;
    logic          IDEX_write_o;
    logic          IDEX_bubble_o;
    logic          freeze_o;
    logic          mul_busy_o;
    logic [PW-1:0] stall_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(.MUL_LAT(ML), .PERF_W(PW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .IDEX_MemRead_i(IDEX_MemRead_i),
        .IDEX_RTaddr_i (IDEX_RTaddr_i),
        .IFID_RSaddr_i (IFID_RSaddr_i),
        .IFID_RTaddr_i (IFID_RTaddr_i),
        .ID_UsesRT_i   (ID_UsesRT_i),
        .ID_Branch_i   (ID_Branch_i),
        .ID_Mul_i      (ID_Mul_i),
        .MemStall_i    (MemStall_i),
        .PC_write_o    (PC_write_o),
        .IFID_write_o  (IFID_write_o),
        .IFID_flush_o  (IFID_flush_o),
        .IDEX_write_o  (IDEX_write_o),
        .IDEX_bubble_o (IDEX_bubble_o),
        .freeze_o      (freeze_o),
        .mul_busy_o    (mul_busy_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        else n_pass++;
    endtask

    // Reference model: remaining multiply stall cycles and a wrapping stall tally
    int            m_left  = 0;
    logic [PW-1:0] m_stall = '0;
    bit            m_valid = 1'b0;

    function automatic bit hazard();
        return IDEX_MemRead_i && IDEX_RTaddr_i != 0 &&
               (IDEX_RTaddr_i == IFID_RSaddr_i ||
                (ID_UsesRT_i && IDEX_RTaddr_i == IFID_RTaddr_i));
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            m_left  <= 0;
            m_stall <= '0;
            m_valid <= 1'b1;
        end else if (MemStall_i) begin
            m_stall <= m_stall + 1'b1;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_stall <= m_stall + 1'b1;
        end else if (hazard()) begin
            m_stall <= m_stall + 1'b1;
        end else if (!ID_Branch_i && ID_Mul_i) begin
            m_left <= ML - 1;
        end
    end

    always @(negedge clk) begin
        logic [6:0] e;
        if (m_valid) begin
            // e = {pc, ifid_w, flush, idex_w, bubble, freeze, mul_busy}
            if (rst_i)                 e = 7'b0011100;
            else if (MemStall_i)       e = {5'b00000, 1'b1, m_left > 0};
            else if (m_left > 0)       e = 7'b0000001;
            else if (hazard())         e = 7'b0001100;
            else if (ID_Branch_i)      e = 7'b1111000;
            else                       e = 7'b1101000;
            chk("PC_write",    32'(PC_write_o),    32'(e[6]));
            chk("IFID_write",  32'(IFID_write_o),  32'(e[5]));
            chk("IFID_flush",  32'(IFID_flush_o),  32'(e[4]));
            chk("IDEX_write",  32'(IDEX_write_o),  32'(e[3]));
            chk("IDEX_bubble", 32'(IDEX_bubble_o), 32'(e[2]));
            chk("freeze",      32'(freeze_o),      32'(e[1]));
            chk("mul_busy",    32'(mul_busy_o),    32'(e[0]));
            chk("stall_cnt",   32'(stall_cnt_o),   32'(m_stall));
        end
    end

    task automatic idle();
        IDEX_MemRead_i = 1'b0; IDEX_RTaddr_i = 5'd0; IFID_RSaddr_i = 5'd0;
        IFID_RTaddr_i  = 5'd0; ID_UsesRT_i   = 1'b0; ID_Branch_i   = 1'b0;
        ID_Mul_i       = 1'b0; MemStall_i    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_pc",     32'(PC_write_o),    32'd0);
        chk("rst_bubble", 32'(IDEX_bubble_o), 32'd1);
        chk("rst_flush",  32'(IFID_flush_o),  32'd1);
        cyc(); rst_i = 1'b1;
        cyc(); rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_pc",   32'(PC_write_o),  32'd1);
        chk("post_rst_cnt",  32'(stall_cnt_o), 32'd0);
        chk("post_rst_busy", 32'(mul_busy_o),  32'd0);

        // Load-use on rs
        cyc(); IDEX_MemRead_i = 1'b1; IDEX_RTaddr_i = 5'd8; IFID_RSaddr_i = 5'd8;
        @(negedge clk);
        chk("lu_pc",     32'(PC_write_o),    32'd0);
        chk("lu_bubble", 32'(IDEX_bubble_o), 32'd1);
        cyc();
        @(negedge clk);
        chk("lu_resume", 32'(PC_write_o),  32'd1);
        chk("lu_cnt",    32'(stall_cnt_o), 32'd1);
        cyc(); IDEX_MemRead_i = 1'b1;
        @(negedge clk);
        chk("lu_r0", 32'(PC_write_o), 32'd1);

        // Dependency through rt only when rt is a source
        cyc(); IDEX_MemRead_i = 1'b1; IDEX_RTaddr_i = 5'd8; IFID_RTaddr_i = 5'd8; IFID_RSaddr_i = 5'd3;
        @(negedge clk);
        chk("rt_unused", 32'(PC_write_o), 32'd1);
        cyc(); IDEX_MemRead_i = 1'b1; IDEX_RTaddr_i = 5'd8; IFID_RTaddr_i = 5'd8; IFID_RSaddr_i = 5'd3;
        ID_UsesRT_i = 1'b1;
        @(negedge clk);
        chk("rt_used", 32'(PC_write_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("rt_cnt", 32'(stall_cnt_o), 32'd2);

        // Multiply occupies EX for ML-1 stall cycles
        cyc(); ID_Mul_i = 1'b1;
        @(negedge clk);
        chk("mul_issue_pc", 32'(PC_write_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("mul_busy_n", 32'(mul_busy_o), 32'd1);
            chk("mul_pc_n",   32'(PC_write_o), 32'd0);
        end
        cyc();
        @(negedge clk);
        chk("mul_done", 32'(mul_busy_o),  32'd0);
        chk("mul_cnt",  32'(stall_cnt_o), 32'd5);

        // Memory stall while the multiply has two cycles left
        cyc(); ID_Mul_i = 1'b1;
        cyc();
        cyc(); MemStall_i = 1'b1;
        @(negedge clk);
        chk("ms_freeze", 32'(freeze_o),   32'd1);
        chk("ms_busy",   32'(mul_busy_o), 32'd1);
        cyc(); MemStall_i = 1'b1;
        cyc();
        @(negedge clk);
        chk("ms_held1", 32'(mul_busy_o), 32'd1);
        cyc();
        @(negedge clk);
        chk("ms_held2", 32'(mul_busy_o), 32'd1);
        cyc();
        @(negedge clk);
        chk("ms_done", 32'(mul_busy_o),  32'd0);
        chk("ms_cnt",  32'(stall_cnt_o), 32'd10);

        // Load-use outranks a taken branch
        cyc(); IDEX_MemRead_i = 1'b1; IDEX_RTaddr_i = 5'd9; IFID_RSaddr_i = 5'd9; ID_Branch_i = 1'b1;
        @(negedge clk);
        chk("br_lu_flush", 32'(IFID_flush_o), 32'd0);
        chk("br_lu_pc",    32'(PC_write_o),   32'd0);
        cyc(); ID_Branch_i = 1'b1;
        @(negedge clk);
        chk("br_flush", 32'(IFID_flush_o), 32'd1);
        chk("br_pc",    32'(PC_write_o),   32'd1);
        cyc();
        @(negedge clk);
        chk("br_cnt", 32'(stall_cnt_o), 32'd11);

        // Random traffic; small register range keeps hazards frequent
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst_i          = ($urandom_range(63) == 0);
            MemStall_i     = ($urandom_range(7) == 0);
            ID_Mul_i       = ($urandom_range(9) == 0);
            ID_Branch_i    = ($urandom_range(5) == 0);
            IDEX_MemRead_i = ($urandom_range(2) == 0);
            ID_UsesRT_i    = $urandom_range(1) != 0;
            IDEX_RTaddr_i  = 5'($urandom_range(3));
            IFID_RSaddr_i  = 5'($urandom_range(3));
            IFID_RTaddr_i  = 5'($urandom_range(3));
        end
        cyc();
        rst_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
